// File: rtl/lvdc_serial_capture_pkg.sv
// Shared types and sizing helpers for the LVDC serial capture block.
// Imported by the top level; keeps the FSM encoding in one place.
package lvdc_serial_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Counter must hold WIDTH-1 and LEAD-1; never narrower than one bit.
  function automatic int cnt_width(input int width, input int lead);
    int m;
    m = 2;
    if (width > m) m = width;
    if (lead > m) m = lead;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/lvdc_serial_capture_shift_chan.sv
// One channel of the serial deserialiser: a WIDTH-bit shift register that
// advances only when EN is high, in MSB-first or LSB-first order.
module lvdc_shift_chan #(
  parameter int WIDTH     = 26,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SDI,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sreg_d = {sreg_q[WIDTH-2:0], SDI};
    end else begin : g_lsb
      assign sreg_d = {SDI, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather
  // than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg_q <= '0;
    end else if (EN) begin
      sreg_q <= sreg_d;
    end
  end

  assign Q = sreg_q;

endmodule

// File: rtl/lvdc_serial_capture.sv
// LVDC serial capture: frames CHANNELS serial inputs on a bit strobe, hands
// completed word sets over a valid/ready holding register, flags drops/aborts.
module lvdc_serial_capture
  import lvdc_serial_capture_pkg::*;
#(
  parameter int WIDTH     = 26,
  parameter int CHANNELS  = 1,
  parameter int LEAD      = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      BIT_STB,
  input  logic                      FRAME,
  input  logic [CHANNELS-1:0]       SDI,
  output logic [CHANNELS*WIDTH-1:0] DOUT,
  output logic                      DOUT_VALID,
  input  logic                      DOUT_READY,
  output logic                      OVERRUN,
  output logic                      ABORT,
  input  logic                      CLR_FLAGS
);

  localparam int              CNT_W      = cnt_width(WIDTH, LEAD);
  localparam logic [CNT_W-1:0] WIDTH_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'((LEAD > 0) ? LEAD - 1 : 0);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      frame_prev_q, frame_prev_d;
  logic                      done_q, done_d;
  logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic                      abort_q, abort_d;

  logic                      frame_start;
  logic                      shift_en;
  logic                      abort_set;
  logic                      overrun_set;
  logic [CHANNELS*WIDTH-1:0] sreg;

  assign frame_start = FRAME & ~frame_prev_q;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      lvdc_shift_chan #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
      ) u_chan (
        .CLK (CLK),
        .RST (RST),
        .EN  (shift_en),
        .SDI (SDI[i]),
        .Q   (sreg[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Framing FSM: everything here advances only on a bit strobe.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_prev_d = frame_prev_q;
    done_d       = 1'b0;
    shift_en     = 1'b0;
    abort_set    = 1'b0;
    if (BIT_STB) begin
      frame_prev_d = FRAME;
      if (frame_start) begin
        abort_set = (state_q == ST_SKIP) || (state_q == ST_SHIFT);
        if (LEAD == 0) begin
          state_d = ST_SHIFT;
          cnt_d   = WIDTH_LOAD;
        end else begin
          state_d = ST_SKIP;
          cnt_d   = LEAD_LOAD;
        end
      end else begin
        case (state_q)
          ST_SKIP: begin
            if (!FRAME) begin
              abort_set = 1'b1;
              state_d   = ST_IDLE;
            end else if (cnt_q == '0) begin
              state_d = ST_SHIFT;
              cnt_d   = WIDTH_LOAD;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_SHIFT: begin
            if (!FRAME) begin
              abort_set = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              shift_en = 1'b1;
              if (cnt_q == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Holding register and sticky flags run every cycle; done arrives one
  // cycle after the final-bit strobe, once sreg holds the last bit.
  always_comb begin
    dout_d      = dout_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    if (done_q) begin
      if (!valid_q || DOUT_READY) begin
        dout_d  = sreg;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (valid_q && DOUT_READY) begin
      valid_d = 1'b0;
    end
    overrun_d = overrun_set ? 1'b1 : (CLR_FLAGS ? 1'b0 : overrun_q);
    abort_d   = abort_set   ? 1'b1 : (CLR_FLAGS ? 1'b0 : abort_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      frame_prev_q <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_prev_q <= frame_prev_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
  assign OVERRUN    = overrun_q;
  assign ABORT      = abort_q;

endmodule

// File: tb/tb_lvdc_serial_capture.sv
// Bench for lvdc_serial_capture: a 1-channel MSB-first instance and a
// 3-channel LSB-first instance share framing; expectations come from words sent.
module tb_lvdc_serial_capture;

  localparam int W = 26;

  logic          clk = 1'b0;
  logic          rst, stb, frame, rdy, clr;
  logic [0:0]    sdi_a;
  logic [2:0]    sdi_b;
  logic [W-1:0]  dout_a;
  logic [3*W-1:0] dout_b;
  logic          valid_a, valid_b, ovr_a, ovr_b, abt_a, abt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transaction-level view of what the consumer should see.
  logic           exp_valid, exp_ovr, exp_abt;
  logic [W-1:0]   exp_dout_a;
  logic [3*W-1:0] exp_dout_b;

  always #5 clk = ~clk;

  lvdc_serial_capture #(.WIDTH(W), .CHANNELS(1), .LEAD(1), .MSB_FIRST(1)) dut_a (
    .CLK(clk), .RST(rst), .BIT_STB(stb), .FRAME(frame), .SDI(sdi_a),
    .DOUT(dout_a), .DOUT_VALID(valid_a), .DOUT_READY(rdy),
    .OVERRUN(ovr_a), .ABORT(abt_a), .CLR_FLAGS(clr)
  );

  lvdc_serial_capture #(.WIDTH(W), .CHANNELS(3), .LEAD(1), .MSB_FIRST(0)) dut_b (
    .CLK(clk), .RST(rst), .BIT_STB(stb), .FRAME(frame), .SDI(sdi_b),
    .DOUT(dout_b), .DOUT_VALID(valid_b), .DOUT_READY(rdy),
    .OVERRUN(ovr_b), .ABORT(abt_b), .CLR_FLAGS(clr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid_a"}, 128'(valid_a), 128'(exp_valid));
    check({tag, "_valid_b"}, 128'(valid_b), 128'(exp_valid));
    check({tag, "_dout_a"},  128'(dout_a),  128'(exp_dout_a));
    check({tag, "_dout_b"},  128'(dout_b),  128'(exp_dout_b));
    check({tag, "_ovr_a"},   128'(ovr_a),   128'(exp_ovr));
    check({tag, "_ovr_b"},   128'(ovr_b),   128'(exp_ovr));
    check({tag, "_abt_a"},   128'(abt_a),   128'(exp_abt));
    check({tag, "_abt_b"},   128'(abt_b),   128'(exp_abt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic f, input logic a, input logic [2:0] b, input int gap);
    stb = 1'b0;
    repeat (gap) tick();
    stb   = 1'b1;
    frame = f;
    sdi_a = a;
    sdi_b = b;
    tick();
    stb = 1'b0;
  endtask

  // Idle-low strobe, start strobe, one lead strobe, then nbits data strobes.
  task automatic frame_head(input int nbits, input logic [W-1:0] wa,
                            input logic [3*W-1:0] wb, input int gap_max);
    strobe(1'b0, 1'b0, 3'b000, 0);
    strobe(1'b1, 1'($urandom), 3'($urandom), $urandom_range(0, gap_max));
    strobe(1'b1, 1'($urandom), 3'($urandom), $urandom_range(0, gap_max));
    for (int k = 0; k < nbits; k++)
      strobe(1'b1, wa[W-1-k], {wb[2*W+k], wb[W+k], wb[k]}, $urandom_range(0, gap_max));
  endtask

  // Leaves the bench 1 time unit after the final-bit strobe edge.
  task automatic send_frame(input logic [W-1:0] wa, input logic [3*W-1:0] wb, input int gap_max);
    frame_head(W, wa, wb, gap_max);
  endtask

  task automatic send_partial(input int nbits, input int gap_max);
    frame_head(nbits, W'($urandom), {W'($urandom), W'($urandom), W'($urandom)}, gap_max);
    strobe(1'b0, 1'b0, 3'b000, 0);
    exp_abt = 1'b1;
  endtask

  // Expected consumer-visible effect of one completed frame.
  task automatic complete(input logic [W-1:0] wa, input logic [3*W-1:0] wb);
    if (exp_valid && !rdy) begin
      exp_ovr = 1'b1;
    end else begin
      exp_valid  = 1'b1;
      exp_dout_a = wa;
      exp_dout_b = wb;
    end
  endtask

  task automatic consume();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_ovr = 1'b0;
    exp_abt = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   wa, wa1;
    logic [3*W-1:0] wb, wb1;

    rst = 1'b1; stb = 1'b0; frame = 1'b0; rdy = 1'b0; clr = 1'b0;
    sdi_a = '0; sdi_b = '0;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_abt = 1'b0;
    exp_dout_a = '0; exp_dout_b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_all("reset");

    // Basic MSB-first capture and one-cycle delivery latency.
    wa = 26'h2AAAAAA;
    wb = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(wa, wb, 0);
    check("t1_latency_not_early", 128'(valid_a), 128'(0));
    tick();
    complete(wa, wb);
    check_all("t1");
    consume();
    check_all("t1_consumed");

    // Three LSB-first channels with distinct patterns.
    wb = {26'h1234567, 26'h3FFFFFF, 26'h0000001};
    wa = W'($urandom);
    send_frame(wa, wb, 1);
    tick();
    complete(wa, wb);
    check_all("t2");
    consume();

    // Back-to-back frames with no consumer: first word held, overrun flagged.
    wa1 = W'($urandom); wb1 = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(wa1, wb1, 0);
    tick();
    complete(wa1, wb1);
    wa = W'($urandom); wb = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(wa, wb, 0);
    tick();
    complete(wa, wb);
    check_all("t3_overrun");
    pulse_clr();
    check_all("t3_cleared");
    consume();

    // Aborted partial frame followed by a good one.
    send_partial(10, 0);
    check_all("t4_no_partial");
    wa = 26'h155AA55; wb = {26'h155AA55, W'($urandom), W'($urandom)};
    send_frame(wa, wb, 0);
    tick();
    complete(wa, wb);
    check_all("t4");

    // Done coincides with accept of the previous word.
    wa = W'($urandom); wb = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(wa, wb, 0);
    rdy = 1'b1;
    tick();
    exp_dout_a = wa; exp_dout_b = wb; exp_valid = 1'b1;
    rdy = 1'b0;
    check_all("t5");

    // Reset in the middle of a frame, then a clean frame.
    frame_head(13, W'($urandom), {W'($urandom), W'($urandom), W'($urandom)}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_abt = 1'b0;
    exp_dout_a = '0; exp_dout_b = '0;
    check_all("t6_reset");
    wa = W'($urandom); wb = {W'($urandom), W'($urandom), W'($urandom)};
    send_frame(wa, wb, 1);
    tick();
    complete(wa, wb);
    check_all("t6");

    // Randomised traffic: ready level, aborts, strobe gaps and flag clears.
    for (int it = 0; it < 40; it++) begin
      rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) send_partial($urandom_range(0, W - 1), 2);
      wa = W'($urandom); wb = {W'($urandom), W'($urandom), W'($urandom)};
      send_frame(wa, wb, 2);
      tick();
      complete(wa, wb);
      check_all("rnd_load");
      tick();
      if (rdy) exp_valid = 1'b0;
      check_all("rnd_after");
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        if (rdy) exp_valid = 1'b0;
        check_all("rnd_clr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
